// File: rtl/hazard_scoreboard.sv
// Decode-stage interlock for a non-forwarding pipeline.
// Tracks the destination registers of instructions between decode and
// writeback, stalls decode while rs1/rs2 depend on one of them, and keeps a
// saturating count of stall cycles. The register file writes through, so an
// instruction already in WB is never a hazard and is not tracked.
module hazard_scoreboard #(
  parameter int DEPTH = 2,  // tracked slots between decode and WB, 1..6
  parameter int CNT_W = 32  // stall-cycle counter width
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             id_valid_i,
  input  logic             id_rd_wren_i,
  input  logic [4:0]       id_rd_addr_i,
  input  logic             id_rs1_used_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             flush_i,
  input  logic             hold_i,
  input  logic             cnt_clr_i,
  output logic             stall_o,
  output logic             id_fire_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // slot 0 is EX, slot DEPTH-1 is the stage just before WB
  logic [DEPTH-1:0] r_slot_vld;
  logic [4:0]       r_slot_addr [DEPTH];
  logic [CNT_W-1:0] r_stall_cnt;

  logic [DEPTH-1:0] w_rs1_hit;
  logic [DEPTH-1:0] w_rs2_hit;
  logic             w_rs1_match;
  logic             w_rs2_match;
  logic             w_stall;
  logic             w_fire;
  logic             w_track_new;

  // per-slot address comparators against both source operands
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign w_rs1_hit[gi] = r_slot_vld[gi] && (r_slot_addr[gi] == id_rs1_addr_i);
      assign w_rs2_hit[gi] = r_slot_vld[gi] && (r_slot_addr[gi] == id_rs2_addr_i);
    end
  endgenerate

  // x0 is hardwired zero, so reading it can never depend on a producer
  assign w_rs1_match = id_rs1_used_i && (id_rs1_addr_i != 5'd0) && (|w_rs1_hit);
  assign w_rs2_match = id_rs2_used_i && (id_rs2_addr_i != 5'd0) && (|w_rs2_hit);

  // stall is reported even during hold so decode sees a stable interlock
  assign w_stall     = id_valid_i && !flush_i && (w_rs1_match || w_rs2_match);
  assign w_fire      = id_valid_i && !w_stall && !flush_i && !hold_i;
  assign w_track_new = w_fire && id_rd_wren_i && (id_rd_addr_i != 5'd0);

  assign stall_o     = w_stall;
  assign id_fire_o   = w_fire;
  assign busy_o      = |r_slot_vld;
  assign stall_cnt_o = r_stall_cnt;

  // slot pipeline: EX loads the issuing writer (or a bubble), older slots shift toward WB
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      if (gi == 0) begin : g_head
        // EX slot captures the instruction leaving decode
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            r_slot_vld[0]  <= 1'b0;
            r_slot_addr[0] <= 5'd0;
          end else if (!hold_i) begin
            r_slot_vld[0]  <= w_track_new;
            r_slot_addr[0] <= w_track_new ? id_rd_addr_i : 5'd0;
          end
        end
      end else begin : g_tail
        // later slots follow their predecessor one stage behind
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            r_slot_vld[gi]  <= 1'b0;
            r_slot_addr[gi] <= 5'd0;
          end else if (!hold_i) begin
            r_slot_vld[gi]  <= r_slot_vld[gi-1];
            r_slot_addr[gi] <= r_slot_addr[gi-1];
          end
        end
      end
    end
  endgenerate

  // saturating stall counter; clear wins over increment, frozen cycles are not counted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (cnt_clr_i) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !hold_i && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (DEPTH=2/CNT_W=32 and
// DEPTH=3/CNT_W=4) share stimulus; both are compared every cycle against a
// model that tracks each in-flight writer by its age since issue.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_rd_wren, id_rs1_used, id_rs2_used;
  logic [4:0] id_rd_addr, id_rs1_addr, id_rs2_addr;
  logic       flush, hold, cnt_clr;

  logic        stall_a, fire_a, busy_a;
  logic [31:0] cnt_a;
  logic        stall_b, fire_b, busy_b;
  logic [3:0]  cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.DEPTH(2), .CNT_W(32)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .id_valid_i(id_valid), .id_rd_wren_i(id_rd_wren), .id_rd_addr_i(id_rd_addr),
    .id_rs1_used_i(id_rs1_used), .id_rs1_addr_i(id_rs1_addr),
    .id_rs2_used_i(id_rs2_used), .id_rs2_addr_i(id_rs2_addr),
    .flush_i(flush), .hold_i(hold), .cnt_clr_i(cnt_clr),
    .stall_o(stall_a), .id_fire_o(fire_a), .busy_o(busy_a), .stall_cnt_o(cnt_a)
  );

  hazard_scoreboard #(.DEPTH(3), .CNT_W(4)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .id_valid_i(id_valid), .id_rd_wren_i(id_rd_wren), .id_rd_addr_i(id_rd_addr),
    .id_rs1_used_i(id_rs1_used), .id_rs1_addr_i(id_rs1_addr),
    .id_rs2_used_i(id_rs2_used), .id_rs2_addr_i(id_rs2_addr),
    .flush_i(flush), .hold_i(hold), .cnt_clr_i(cnt_clr),
    .stall_o(stall_b), .id_fire_o(fire_b), .busy_o(busy_b), .stall_cnt_o(cnt_b)
  );

  // ---------------- reference model ----------------
  // Each issued writer is a record {rd, age}; age counts pipeline advances
  // since it entered EX. It reaches WB (and stops mattering) at age == depth.
  localparam int NREC = 8;
  int     m_depth [2] = '{2, 3};
  longint m_cmax  [2] = '{64'd4294967295, 64'd15};
  int     rec_rd  [2][NREC];
  int     rec_age [2][NREC];
  longint m_cnt   [2];

  task automatic m_reset();
    for (int m = 0; m < 2; m++) begin
      for (int e = 0; e < NREC; e++) begin
        rec_age[m][e] = -1;
        rec_rd[m][e]  = 0;
      end
      m_cnt[m] = 0;
    end
  endtask

  function automatic bit m_depends(int m, logic used, logic [4:0] a);
    if (!used || a == 5'd0) return 1'b0;
    for (int e = 0; e < NREC; e++)
      if (rec_age[m][e] >= 0 && rec_rd[m][e] == int'(a)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_stall(int m);
    return id_valid && !flush &&
           (m_depends(m, id_rs1_used, id_rs1_addr) || m_depends(m, id_rs2_used, id_rs2_addr));
  endfunction

  function automatic bit m_fire(int m);
    return id_valid && !m_stall(m) && !flush && !hold;
  endfunction

  function automatic bit m_busy(int m);
    for (int e = 0; e < NREC; e++)
      if (rec_age[m][e] >= 0) return 1'b1;
    return 1'b0;
  endfunction

  // apply one clock edge to the model using the inputs present before the edge
  task automatic m_advance(int m);
    bit s, f;
    s = m_stall(m);
    f = m_fire(m);
    if (!hold) begin
      for (int e = 0; e < NREC; e++) begin
        if (rec_age[m][e] >= 0) begin
          rec_age[m][e]++;
          if (rec_age[m][e] >= m_depth[m]) rec_age[m][e] = -1;
        end
      end
      if (f && id_rd_wren && id_rd_addr != 5'd0) begin
        for (int e = 0; e < NREC; e++) begin
          if (rec_age[m][e] < 0) begin
            rec_age[m][e] = 0;
            rec_rd[m][e]  = int'(id_rd_addr);
            break;
          end
        end
      end
    end
    if (cnt_clr) m_cnt[m] = 0;
    else if (s && !hold && m_cnt[m] < m_cmax[m]) m_cnt[m]++;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("a_stall", 32'(stall_a), 32'(m_stall(0)));
    check("a_fire",  32'(fire_a),  32'(m_fire(0)));
    check("a_busy",  32'(busy_a),  32'(m_busy(0)));
    check("a_cnt",   cnt_a,        32'(m_cnt[0]));
    check("b_stall", 32'(stall_b), 32'(m_stall(1)));
    check("b_fire",  32'(fire_b),  32'(m_fire(1)));
    check("b_busy",  32'(busy_b),  32'(m_busy(1)));
    check("b_cnt",   32'(cnt_b),   32'(m_cnt[1]));
  endtask

  // one decode cycle: drive, check mid-cycle, clock, update model
  task automatic step(input logic v, input logic wren, input logic [4:0] rd,
                      input logic u1, input logic [4:0] a1,
                      input logic u2, input logic [4:0] a2,
                      input logic fl, input logic hd, input logic clr);
    id_valid = v; id_rd_wren = wren; id_rd_addr = rd;
    id_rs1_used = u1; id_rs1_addr = a1;
    id_rs2_used = u2; id_rs2_addr = a2;
    flush = fl; hold = hd; cnt_clr = clr;
    @(negedge clk);
    check_all();
    $display("t=%0t v=%b w=%b rd=%0d rs1=%b/%0d rs2=%b/%0d fl=%b hd=%b clr=%b | stall=%b/%b fire=%b/%b busy=%b/%b cnt=%0d/%0d",
             $time, v, wren, rd, u1, a1, u2, a2, fl, hd, clr,
             stall_a, stall_b, fire_a, fire_b, busy_a, busy_b, cnt_a, cnt_b);
    @(posedge clk);
    m_advance(0);
    m_advance(1);
    #1;
  endtask

  task automatic idle(input logic clr);
    step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, clr);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_reset();
    rst_n = 1'b0;
    id_valid = 0; id_rd_wren = 0; id_rd_addr = 0;
    id_rs1_used = 0; id_rs1_addr = 0; id_rs2_used = 0; id_rs2_addr = 0;
    flush = 0; hold = 0; cnt_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(stall_a), 32'd0);
    check("rst_busy",  32'(busy_a),  32'd0);
    check("rst_fire",  32'(fire_a),  32'd0);
    check("rst_cnt",   cnt_a,        32'd0);
    rst_n = 1'b1;
    idle(1'b0);

    // dependent instruction right behind its producer: DEPTH stall cycles
    idle(1'b1);
    step(1, 1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    repeat (3) step(1, 1, 5'd6, 1, 5'd5, 1, 5'd1, 0, 0, 0);
    check("s1_cnt_a", cnt_a, 32'd2);
    idle(1'b0); idle(1'b0);

    // consumer two and three cycles behind the producer
    step(1, 1, 5'd7, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    idle(1'b0);
    repeat (2) step(1, 0, 5'd0, 0, 5'd0, 1, 5'd7, 0, 0, 0);
    step(1, 1, 5'd7, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    idle(1'b0); idle(1'b0);
    step(1, 0, 5'd0, 0, 5'd0, 1, 5'd7, 0, 0, 0);
    idle(1'b0); idle(1'b0);

    // x0 writers and non-writers never create a dependency
    step(1, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    step(1, 0, 5'd8, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    step(1, 0, 5'd0, 1, 5'd0, 1, 5'd8, 0, 0, 0);
    idle(1'b0); idle(1'b0); idle(1'b0);

    // back-to-back writers of x9
    step(1, 1, 5'd9, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    step(1, 1, 5'd9, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    repeat (4) step(1, 0, 5'd0, 1, 5'd9, 0, 5'd0, 0, 0, 0);
    idle(1'b0); idle(1'b0); idle(1'b0);

    // hold with a stalled consumer in decode
    idle(1'b1);
    step(1, 1, 5'd3, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    repeat (3) step(1, 0, 5'd0, 1, 5'd3, 0, 5'd0, 0, 1, 0);
    check("hold_cnt_a", cnt_a, 32'd0);
    repeat (4) step(1, 0, 5'd0, 1, 5'd3, 0, 5'd0, 0, 0, 0);
    idle(1'b0); idle(1'b0); idle(1'b0);

    // flush of a dependent instruction
    step(1, 1, 5'd4, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    step(1, 1, 5'd4, 1, 5'd4, 0, 5'd0, 1, 0, 0);
    repeat (3) step(1, 0, 5'd0, 1, 5'd4, 0, 5'd0, 0, 0, 0);
    idle(1'b0); idle(1'b0); idle(1'b0);

    // saturation of the 4-bit counter, then clear during a stall
    idle(1'b1);
    for (int i = 0; i < 7; i++) begin
      step(1, 1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 0, 0);
      repeat (3) step(1, 0, 5'd0, 1, 5'd5, 0, 5'd0, 0, 0, 0);
    end
    check("sat_cnt_b", 32'(cnt_b), 32'd15);
    step(1, 1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    step(1, 0, 5'd0, 1, 5'd5, 0, 5'd0, 0, 0, 1);
    check("clr_cnt_b", 32'(cnt_b), 32'd0);
    idle(1'b0); idle(1'b0); idle(1'b0);

    // asynchronous reset while stalled
    step(1, 1, 5'd12, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    step(1, 0, 5'd0, 1, 5'd12, 0, 5'd0, 0, 0, 0);
    id_valid = 1; id_rs1_used = 1; id_rs1_addr = 5'd12;
    #1;
    check("pre_rst_stall", 32'(stall_a), 32'(m_stall(0)));
    rst_n = 1'b0;
    #1;
    m_reset();
    check("arst_stall", 32'(stall_a), 32'd0);
    check("arst_busy",  32'(busy_a),  32'd0);
    check("arst_cnt",   cnt_a,        32'd0);
    check("arst_busy_b", 32'(busy_b), 32'd0);
    id_valid = 0; id_rs1_used = 0; id_rs1_addr = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 0, 5'd0, 1, 5'd12, 0, 5'd0, 0, 0, 0);

    // randomized traffic over a small register set to provoke dependencies
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 29) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
